light_fade_driver: RTL and testbench
====================================

# light_fade_driver

Downstream stage of the lighting controller. Accepts the 16-bit `lightstate` on/off vector over a valid/ready handshake and ramps each light's 4-bit brightness one step per fade tick toward its target. Drives one PWM output per light from a shared 15-step PWM counter. Signals `done` when all lights have settled.

## Interface
- `NUM_LIGHTS`, 16, number of light channels; must match the `lightstate` width.
- `LEVEL_W`, 4, brightness level width; levels run 0..15.
- `TICK_DIV`, 1000, clock cycles per fade step; must be ≥ 2.

- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `state_valid` in 1: upstream has a new `lightstate`.
- `state_ready` out 1: block can accept a new `lightstate`.
- `lightstate` in 16: bit i = 1 means light i on.
- `max_level` in 4: brightness used for on-lights; sampled at accept.
- `fade_en` in 1: 1 = ramp, 0 = jump; sampled at accept.
- `pwm_out` out 16: per-light PWM drive.
- `busy` out 1: high while in FADE.
- `done` out 1: one-cycle pulse when all levels equal their targets.

One clock; reset is asynchronous and active-high.

## Operation
- FSM has two states, IDLE and FADE.
- `state_ready` is a register equal to (state == IDLE).
- Accept occurs when `state_valid && state_ready` at a rising edge.
- On accept:
  - Per light, target[i] = `lightstate`[i] ? `max_level` : 0. Targets are latched.
  - tick_cnt is cleared.
  - If `fade_en` = 0, or all targets already equal the current levels: level[i] <= target[i], state stays IDLE, and `done` pulses in the next cycle.
  - Otherwise: state goes to FADE, and `state_ready` and `busy` drop.
- In FADE:
  - tick_cnt counts 0..TICK_DIV-1.
  - At tick_cnt == TICK_DIV-1, each level moves exactly 1 toward its target (unsigned, no overshoot) and tick_cnt wraps to 0.
  - If the post-step levels all equal their targets, the FSM returns to IDLE at that same edge, `done` = 1 for one cycle, and `state_ready` returns to 1.
- `state_valid` while `state_ready` = 0 is ignored; upstream holds it.
- PWM:
  - pwm_cnt is free-running 0..14 and wraps to 0.
  - `pwm_out`[i] <= (level[i] > pwm_cnt), registered.
  - Level 0 is always low, level 15 is always high, and level k is high k of every 15 cycles.

## Timing
- Reset values: levels 0, targets 0, `pwm_out` 0, `state_ready` 0, `busy` 0, `done` 0, pwm_cnt 0, tick_cnt 0, state IDLE.
- `state_ready` rises on the first clock edge after `rst` deasserts.
- Fade latency from the accept edge: TICK_DIV × max|target − level| cycles until the final step edge. `done` is high in the cycle that follows that edge.
- Jump latency (`fade_en` = 0): levels update at the accept edge, and `pwm_out` reflects them one edge later.
- `pwm_out` lags level by exactly one cycle.
- `rst` mid-fade clears all state immediately (asynchronously). `pwm_out` goes 0 without waiting for an edge.
- If `max_level` changes during FADE, it has no effect until the next accept.

## Structure
- Package `smart_home_pkg`:
  - constants `NUM_LIGHTS`, `LEVEL_W`, `PWM_MAX` (= 14);
  - FSM state enum {IDLE, FADE}.
- Sub-module `light_pwm_channel`:
  - holds level[i] and target[i] registers;
  - steps toward the target on a `step` strobe and loads the target directly on a `jump` strobe;
  - outputs `at_target` and the registered PWM bit;
  - takes pwm_cnt as an input.
- Top level: FSM, tick_cnt, pwm_cnt, 16 channel instances, and the AND-reduce of the `at_target` bits.

## Test plan
- Reset: hold `rst` while driving `state_valid` = 1 → `pwm_out` = 0, `state_ready` = 0, `done` = 0. Release → `state_ready` = 1 after one edge. No accept occurs while `rst` is high.
- Fade up (TICK_DIV = 4): `max_level` = 4, `lightstate` = 16'h0003, `fade_en` = 1 →
  - `state_ready` drops for 16 cycles;
  - levels 0 and 1 step 1, 2, 3, 4 every 4 cycles;
  - `done` pulses once and `state_ready` returns;
  - `pwm_out`[15:2] stays 0;
  - a second `state_valid` during the fade is not accepted.
- PWM duty: light 0 at level 4 → `pwm_out`[0] high 4 of each 15 cycles. Light at level 15 → constantly high.
- Jump: `fade_en` = 0, `lightstate` = 16'h8000, `max_level` = 15 → `pwm_out`[15] = 1 two edges after accept, `done` pulses, `state_ready` stays 1.
- Fade down: from 16'h0003 at level 4, send 16'h0000 → 4 down-steps, then `done`, with all `pwm_out` = 0.
- Reset mid-fade: assert `rst` after 2 steps → `pwm_out` = 0 asynchronously, `busy` = 0. After release a new accept fades from level 0.

Source files
------------

// File: rtl/smart_home_pkg.sv
// Shared constants and types for the lighting controller fade stage.
//   NUM_LIGHTS : number of light channels (width of lightstate / pwm_out)
//   LEVEL_W    : brightness level width, levels 0..15
//   PWM_MAX    : last value of the shared PWM counter (counts 0..PWM_MAX)
//   fade_state_t : IDLE / FADE controller states
package smart_home_pkg;
    localparam int NUM_LIGHTS = 16;
    localparam int LEVEL_W    = 4;
    localparam logic [LEVEL_W-1:0] PWM_MAX = 4'd14;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_t;
endpackage

// File: rtl/light_pwm_channel.sv
// One light channel: holds the current brightness level and its latched
// target, ramps one step toward the target on step, loads it directly on jump,
// and drives a registered PWM bit compared against the shared PWM counter.
//   clk, rst       : clock, async active-high reset
//   load           : latch tgt_in as the new target
//   jump           : load tgt_in straight into the level
//   step           : move level one step toward the target
//   tgt_in         : candidate target for this channel
//   pwm_cnt        : shared PWM counter, 0..PWM_MAX
//   at_target      : level equals latched target
//   tgt_match      : level already equals tgt_in
//   settles_on_step: level will equal target after the next step
//   pwm            : registered PWM drive (level > pwm_cnt)
module light_pwm_channel
    import smart_home_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               jump,
    input  logic               step,
    input  logic [LEVEL_W-1:0] tgt_in,
    input  logic [LEVEL_W-1:0] pwm_cnt,
    output logic               at_target,
    output logic               tgt_match,
    output logic               settles_on_step,
    output logic               pwm
);
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] r_target;
    logic               r_pwm;
    logic [LEVEL_W-1:0] w_level_next;

    // Step toward the target by one, never past it; unsigned compare avoids wrap.
    always_comb begin
        w_level_next = r_level;
        if (r_level < r_target)
            w_level_next = r_level + LEVEL_W'(1);
        else if (r_level > r_target)
            w_level_next = r_level - LEVEL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level  <= '0;
            r_target <= '0;
            r_pwm    <= 1'b0;
        end else begin
            r_pwm <= (r_level > pwm_cnt);
            if (load)
                r_target <= tgt_in;
            if (jump)
                r_level <= tgt_in;
            else if (step)
                r_level <= w_level_next;
        end
    end

    assign at_target       = (r_level == r_target);
    assign tgt_match       = (r_level == tgt_in);
    assign settles_on_step = (w_level_next == r_target);
    assign pwm             = r_pwm;
endmodule

// File: rtl/light_fade_driver.sv
// Fade driver: accepts a lightstate vector over valid/ready, ramps each
// light's brightness one level per fade tick (or jumps straight there), and
// drives one PWM output per light from a shared 15-step counter.
//   clk, rst     : clock, async active-high reset
//   state_valid  : upstream offers a lightstate
//   state_ready  : accepting a new lightstate (registered, high in IDLE)
//   lightstate   : per-light on/off request
//   max_level    : brightness for on-lights, sampled at accept
//   fade_en      : 1 = ramp, 0 = jump, sampled at accept
//   pwm_out      : per-light PWM drive
//   busy         : high while fading
//   done         : one-cycle pulse when all lights reach their targets
//
// state | meaning
// IDLE  | waiting for a lightstate; levels stable at their targets
// FADE  | stepping levels toward targets every TICK_DIV cycles
module light_fade_driver
    import smart_home_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  state_valid,
    output logic                  state_ready,
    input  logic [NUM_LIGHTS-1:0] lightstate,
    input  logic [LEVEL_W-1:0]    max_level,
    input  logic                  fade_en,
    output logic [NUM_LIGHTS-1:0] pwm_out,
    output logic                  busy,
    output logic                  done
);
    localparam int TICK_W = $clog2(TICK_DIV);

    fade_state_t          r_state;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [LEVEL_W-1:0]   r_pwm_cnt;

    logic                  w_accept;
    logic                  w_tick_end;
    logic                  w_step;
    logic                  w_jump;
    logic                  w_all_match;
    logic                  w_all_settle;
    logic [NUM_LIGHTS-1:0] w_at_target;
    logic [NUM_LIGHTS-1:0] w_tgt_match;
    logic [NUM_LIGHTS-1:0] w_settle;

    // r_ready is only ever high in IDLE, so it alone qualifies an accept.
    assign w_accept     = state_valid && r_ready;
    assign w_tick_end   = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_step       = (r_state == FADE) && w_tick_end;
    assign w_all_match  = &w_tgt_match;
    assign w_all_settle = &w_settle;
    assign w_jump       = w_accept && (!fade_en || w_all_match);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LIGHTS; gi++) begin : g_ch
            light_pwm_channel u_ch (
                .clk             (clk),
                .rst             (rst),
                .load            (w_accept),
                .jump            (w_jump),
                .step            (w_step),
                .tgt_in          (lightstate[gi] ? max_level : '0),
                .pwm_cnt         (r_pwm_cnt),
                .at_target       (w_at_target[gi]),
                .tgt_match       (w_tgt_match[gi]),
                .settles_on_step (w_settle[gi]),
                .pwm             (pwm_out[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pwm_cnt <= '0;
        else if (r_pwm_cnt == PWM_MAX)
            r_pwm_cnt <= '0;
        else
            r_pwm_cnt <= r_pwm_cnt + LEVEL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_tick_cnt <= '0;
                        if (w_jump) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= FADE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                FADE: begin
                    if (w_tick_end) begin
                        r_tick_cnt <= '0;
                        // Leave on the same edge as the final step.
                        if (w_all_settle) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_ready = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;

    // at_target is kept for observability; settle detection uses the post-step view.
    logic w_unused;
    assign w_unused = &w_at_target;
endmodule

// File: tb/tb_light_fade_driver.sv
module tb_light_fade_driver;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        state_valid;
    logic        state_ready;
    logic [15:0] lightstate;
    logic [3:0]  max_level;
    logic        fade_en;
    logic [15:0] pwm_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int mdl[16];

    light_fade_driver #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .state_valid(state_valid), .state_ready(state_ready),
        .lightstate(lightstate), .max_level(max_level), .fade_en(fade_en),
        .pwm_out(pwm_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one lightstate; the model returns the expected done latency.
    task automatic send(input logic [15:0] ls, input logic [3:0] ml, input logic fe,
                        output int acc, output int lat);
        int maxd;
        int t;
        int d;
        maxd = 0;
        for (int i = 0; i < 16; i++) begin
            t = ls[i] ? int'(ml) : 0;
            d = (t > mdl[i]) ? t - mdl[i] : mdl[i] - t;
            if (d > maxd) maxd = d;
            mdl[i] = t;
        end
        lat = (!fe || maxd == 0) ? 0 : TD * maxd;
        chk("ready_before_send", state_ready, 1'b1);
        lightstate = ls; max_level = ml; fade_en = fe; state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int got;
        got = -1;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                got = cyc;
                break;
            end
            tick();
        end
        chk(tag, got, exp_q.pop_front());
    endtask

    task automatic duty(input string tag, input int ch, input int exp);
        int n;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            if (pwm_out[ch]) n++;
            tick();
        end
        chk(tag, n, exp);
    endtask

    initial begin
        int acc, lat, low, got;
        logic [13:0] hi;
        for (int i = 0; i < 16; i++) mdl[i] = 0;

        // Reset held with valid asserted
        rst = 1'b1; state_valid = 1'b1; lightstate = 16'hFFFF; max_level = 4'd15; fade_en = 1'b0;
        tick(); tick(); tick();
        chk("rst_pwm", pwm_out, 16'h0);
        chk("rst_ready", state_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        state_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_before_edge", state_ready, 1'b0);
        tick();
        chk("ready_after_rel", state_ready, 1'b1);
        tick();
        chk("no_accept_in_rst", pwm_out, 16'h0);

        // Fade up with a second valid offered mid-fade
        send(16'h0003, 4'd4, 1'b1, acc, lat);
        exp_q.push_back(acc + lat);
        chk("fade_up_busy", busy, 1'b1);
        state_valid = 1'b1; lightstate = 16'hFFFF;
        low = 0; hi = '0; got = -1;
        for (int k = 0; k < 100; k++) begin
            if (k == 6) begin state_valid = 1'b0; lightstate = 16'h0; end
            if (done) begin got = cyc; break; end
            if (!state_ready) low++;
            hi |= pwm_out[15:2];
            tick();
        end
        chk("fade_up_done", got, exp_q.pop_front());
        chk("fade_up_ready_low", low, 16);
        chk("fade_up_hi_zero", hi, 14'h0);
        chk("fade_up_ready_back", state_ready, 1'b1);
        chk("fade_up_busy_off", busy, 1'b0);
        tick();
        chk("done_one_cycle", done, 1'b0);
        duty("duty_l0", 0, mdl[0]);
        duty("duty_l1", 1, mdl[1]);
        chk("no_second_accept", pwm_out[15:2], 14'h0);

        // Jump to full brightness on light 15
        send(16'h8000, 4'd15, 1'b0, acc, lat);
        exp_q.push_back(acc + lat);
        wait_done("jump_done");
        chk("jump_ready", state_ready, 1'b1);
        tick();
        chk("jump_pwm", pwm_out, 16'h8000);
        chk("jump_ready2", state_ready, 1'b1);
        duty("duty_l15", 15, 15);

        // Jump back to 0003 at level 4, then fade down
        send(16'h0003, 4'd4, 1'b0, acc, lat);
        exp_q.push_back(acc + lat);
        wait_done("jump2_done");
        tick();
        send(16'h0000, 4'd4, 1'b1, acc, lat);
        exp_q.push_back(acc + lat);
        wait_done("fade_down_done");
        tick();
        chk("fade_down_pwm", pwm_out, 16'h0);

        // Targets already met with fade enabled: immediate done
        send(16'h0000, 4'd7, 1'b1, acc, lat);
        exp_q.push_back(acc + lat);
        wait_done("same_target_done");
        chk("same_target_busy", busy, 1'b0);
        chk("same_target_ready", state_ready, 1'b1);
        tick();

        // Reset mid-fade
        send(16'h0003, 4'd15, 1'b0, acc, lat);
        exp_q.push_back(acc + lat);
        wait_done("jump15_done");
        tick();
        send(16'h0000, 4'd15, 1'b1, acc, lat);
        for (int k = 0; k < 20 && cyc < acc + 2 * TD; k++) tick();
        for (int k = 0; k < 3 && !pwm_out[0]; k++) tick();
        chk("pre_rst_pwm_high", pwm_out[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pwm", pwm_out, 16'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", state_ready, 1'b0);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        tick();
        chk("post_rst_ready", state_ready, 1'b1);
        send(16'h0001, 4'd3, 1'b1, acc, lat);
        exp_q.push_back(acc + lat);
        wait_done("post_rst_fade_done");
        tick();
        duty("post_rst_duty", 0, mdl[0]);
        chk("post_rst_l1_off", pwm_out[1], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
